// File: rtl/xcore_bpu_update_if.sv
// Update/lookup bundle between the MEM resolution unit, the IF stage and the BPU.
// master = resolution/fetch side driving requests, slave = the BPU.
interface xcore_bpu_update_if #(
  parameter int GHR_W = 6,
  parameter int CNT_W = 32
);
  logic             i_bjp_req;
  logic [31:0]      i_bjp_instr_pc;
  logic [2:0]       i_bjp_instr_type;
  logic [1:0]       i_bjp_update_bits;
  logic             i_bjp_jump_target;
  logic             i_bjp_predict_res;
  logic [31:0]      i_bjp_target;
  logic [31:0]      i_if_pc;
  logic             o_bp_ready;
  logic             o_bp_hit;
  logic             o_bp_deci;
  logic [31:0]      o_bp_target;
  logic [1:0]       o_bp_bim_bits;
  logic [GHR_W-1:0] o_bp_ghr;
  logic [CNT_W-1:0] o_bp_mispred_cnt;

  modport master (
    output i_bjp_req, i_bjp_instr_pc, i_bjp_instr_type, i_bjp_update_bits,
           i_bjp_jump_target, i_bjp_predict_res, i_bjp_target, i_if_pc,
    input  o_bp_ready, o_bp_hit, o_bp_deci, o_bp_target, o_bp_bim_bits,
           o_bp_ghr, o_bp_mispred_cnt
  );

  modport slave (
    input  i_bjp_req, i_bjp_instr_pc, i_bjp_instr_type, i_bjp_update_bits,
           i_bjp_jump_target, i_bjp_predict_res, i_bjp_target, i_if_pc,
    output o_bp_ready, o_bp_hit, o_bp_deci, o_bp_target, o_bp_bim_bits,
           o_bp_ghr, o_bp_mispred_cnt
  );
endinterface

// File: rtl/xcore_bpu_update.sv
// gshare BIM + direct-mapped BTB + GHR, updated from MEM resolution, looked up from IF.
// Define XCORE_BPU_BYPASS_EN to forward a same-cycle update into the lookup (write-first).
module xcore_bpu_update #(
  parameter int IDX_W = 6,
  parameter int GHR_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input logic               i_clk,
  input logic               i_rst,
  xcore_bpu_update_if.slave bp
);
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            init_cnt_q, init_cnt_d;
  logic [GHR_W-1:0]            ghr_q, ghr_d;
  logic [CNT_W-1:0]            mis_q, mis_d;
  logic [DEPTH-1:0][1:0]       bim_q;
  logic [DEPTH-1:0]            btb_vld_q, btb_jal_q;
  logic [DEPTH-1:0][TAG_W-1:0] btb_tag_q;
  logic [DEPTH-1:0][31:0]      btb_tgt_q;

  logic             run, upd_br, upd_jal, btb_we;
  logic [IDX_W-1:0] ghr_ext, u_bim_idx, u_btb_idx, l_bim_idx, l_btb_idx;
  logic [TAG_W-1:0] u_tag, l_tag;
  logic [1:0]       rd_bim;
  logic             rd_vld, rd_jal, hit, deci;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_tgt;
  logic             unused_pc;

  assign run       = (state_q == ST_RUN);
  assign upd_br    = run && bp.i_bjp_req && (bp.i_bjp_instr_type == 3'b100);
  assign upd_jal   = run && bp.i_bjp_req && (bp.i_bjp_instr_type == 3'b010);
  assign btb_we    = upd_jal || (upd_br && bp.i_bjp_jump_target);
  assign ghr_ext   = IDX_W'(ghr_q);
  assign u_btb_idx = bp.i_bjp_instr_pc[IDX_W+1:2];
  assign u_bim_idx = u_btb_idx ^ ghr_ext;
  assign u_tag     = bp.i_bjp_instr_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign l_btb_idx = bp.i_if_pc[IDX_W+1:2];
  assign l_bim_idx = l_btb_idx ^ ghr_ext;
  assign l_tag     = bp.i_if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc = ^{bp.i_bjp_instr_pc[1:0], bp.i_bjp_instr_pc[31:IDX_W+TAG_W+2],
                       bp.i_if_pc[1:0], bp.i_if_pc[31:IDX_W+TAG_W+2]};

  always_comb begin : fsm_next
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + IDX_W'(1);
      if (&init_cnt_q) state_d = ST_RUN;
    end
  end

  always_comb begin : arch_next
    ghr_d = ghr_q;
    mis_d = mis_q;
    if (upd_br) ghr_d = {ghr_q[GHR_W-2:0], bp.i_bjp_jump_target};
    // Counter sticks at all-ones instead of wrapping.
    if ((upd_br || upd_jal) && bp.i_bjp_predict_res && !(&mis_q)) mis_d = mis_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ghr_q      <= '0;
      mis_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ghr_q      <= ghr_d;
      mis_q      <= mis_d;
    end
  end

  // Table storage has no reset; the INIT sweep gives it a defined state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (!run) begin
        bim_q[init_cnt_q]     <= 2'b01;
        btb_vld_q[init_cnt_q] <= 1'b0;
      end else begin
        if (upd_br) bim_q[u_bim_idx] <= bp.i_bjp_update_bits;
        if (btb_we) begin
          btb_vld_q[u_btb_idx] <= 1'b1;
          btb_tag_q[u_btb_idx] <= u_tag;
          btb_tgt_q[u_btb_idx] <= bp.i_bjp_target;
          btb_jal_q[u_btb_idx] <= upd_jal;
        end
      end
    end
  end

  always_comb begin : lookup
    rd_bim = bim_q[l_bim_idx];
    rd_vld = btb_vld_q[l_btb_idx];
    rd_tag = btb_tag_q[l_btb_idx];
    rd_tgt = btb_tgt_q[l_btb_idx];
    rd_jal = btb_jal_q[l_btb_idx];
`ifdef XCORE_BPU_BYPASS_EN
    if (upd_br && (u_bim_idx == l_bim_idx)) rd_bim = bp.i_bjp_update_bits;
    if (btb_we && (u_btb_idx == l_btb_idx)) begin
      rd_vld = 1'b1;
      rd_tag = u_tag;
      rd_tgt = bp.i_bjp_target;
      rd_jal = upd_jal;
    end
`endif
    hit  = run && rd_vld && (rd_tag == l_tag);
    deci = hit && (rd_jal || rd_bim[1]);
  end

  assign bp.o_bp_ready       = run;
  assign bp.o_bp_hit         = hit;
  assign bp.o_bp_deci        = deci;
  assign bp.o_bp_target      = deci ? rd_tgt : bp.i_if_pc + 32'd4;
  assign bp.o_bp_bim_bits    = run ? rd_bim : 2'b01;
  assign bp.o_bp_ghr         = ghr_q;
  assign bp.o_bp_mispred_cnt = mis_q;
endmodule

// File: doc/xcore_bpu_update.md
Name: xcore_bpu_update

Overview:
- Front-end consumer of the backend-update interface driven by the MEM-stage branch/jump resolution unit.
- Holds the gshare BIM table (2-bit counters), the architectural GHR, a direct-mapped BTB, and a misprediction counter.
- Applies one resolved update per cycle and serves a same-cycle combinational prediction lookup for the IF-stage PC.
- A reset-time init FSM sweeps both tables before predictions are enabled.

Parameters:
- IDX_W, 6: table index width; BIM and BTB depth is 2^IDX_W.
- GHR_W, 6: GHR width; must be <= IDX_W. GHR is zero-extended to IDX_W for hashing.
- TAG_W, 8: BTB tag width.
- CNT_W, 32: misprediction counter width.

Ports:
- i_clk  input  1  clock; single clock domain
- i_rst  input  1  reset; synchronous, active-high
- i_bjp_req  input  1  update valid from MEM resolution
- i_bjp_instr_pc  input  32  PC of resolved instruction
- i_bjp_instr_type  input  3  100 = conditional branch, 010 = jal, other = no-op
- i_bjp_update_bits  input  2  new BIM counter value, precomputed by resolution unit
- i_bjp_jump_target  input  1  1 = instruction actually taken
- i_bjp_predict_res  input  1  1 = mispredicted
- i_bjp_target  input  32  resolved taken target
- i_if_pc  input  32  lookup PC
- o_bp_ready  output  1  tables initialised
- o_bp_hit  output  1  BTB tag hit for i_if_pc
- o_bp_deci  output  1  predict taken
- o_bp_target  output  32  predicted next PC
- o_bp_bim_bits  output  2  BIM counter read for i_if_pc
- o_bp_ghr  output  GHR_W  current GHR
- o_bp_mispred_cnt  output  CNT_W  saturating misprediction count

Behaviour:
- Index functions:
  - BIM index = i_*_pc[IDX_W+1:2] ^ ghr.
  - BTB index = pc[IDX_W+1:2].
  - BTB tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- FSM states: INIT, RUN.
  - i_rst high (any cycle, including mid-INIT): state=INIT, init counter=0, ghr=0, mispred_cnt=0, o_bp_ready=0.
  - INIT: each cycle write bim[cnt]=01 and btb_valid[cnt]=0, then cnt++. After the write of entry 2^IDX_W-1, move to RUN. INIT therefore lasts exactly 2^IDX_W cycles.
  - RUN: o_bp_ready=1; no exit except reset.
- During INIT:
  - i_bjp_req is ignored.
  - o_bp_hit=0, o_bp_deci=0, o_bp_target=i_if_pc+4, o_bp_bim_bits=01.
- Update in RUN, applied at the clock edge where i_bjp_req=1:
  - type 100:
    - bim[idx] <= i_bjp_update_bits, with idx computed from the pre-shift GHR.
    - ghr <= {ghr[GHR_W-2:0], i_bjp_jump_target}.
    - If taken: BTB entry <= {valid=1, tag, i_bjp_target, is_jal=0}.
  - type 010: BTB entry <= {valid=1, tag, i_bjp_target, is_jal=1}. BIM and GHR untouched.
  - Other types: no state change.
  - mispred_cnt += i_bjp_predict_res for types 100 and 010. Saturates at all-ones; never wraps.
- Lookup (combinational, RUN):
  - o_bp_hit = valid & tag match.
  - o_bp_deci = hit & (is_jal | bim[1]).
  - o_bp_target = deci ? btb_target : i_if_pc+4. The +4 wraps modulo 2^32.
- Simultaneous update and lookup: lookup sees pre-edge state, i.e. the old table contents and old GHR. See the optional feature for the alternative.
- BTB conflict: a new write overwrites the entry unconditionally, replacing any old tag.

Optional Feature:
- Macro: XCORE_BPU_BYPASS_EN.
- Defined: when i_bjp_req is valid in RUN and the update index equals the lookup index in the same cycle, the lookup returns the incoming values (write-first):
  - BIM matched by BIM index, using the pre-update GHR.
  - BTB matched by BTB index plus tag.
  - Taken branch/jal entries are forwarded as hit with i_bjp_target.
  - o_bp_ghr is unaffected until the edge.
- Undefined: read-old behaviour as specified above.

Test Plan:
- Reset, IDX_W=6, i_if_pc=0x100 -> o_bp_ready=0 for 64 cycles, rises on cycle 64; o_bp_deci=0, o_bp_target=0x104, o_bp_bim_bits=01.
- Reset re-asserted at INIT cycle 30 -> o_bp_ready stays 0 a further 64 cycles after release; ghr=0, counter=0.
- RUN, ghr=0: update type 100, pc=0x100, taken, bits=10, target=0x200; then lookup 0x100 -> ghr=000001, hit=1, bim index=1 reads 01, deci=0, target=0x104. Repeat with ghr=0 and pc=0x104 (index 1) -> deci per bim[1].
- Update type 010, pc=0x80, target=0x400; lookup 0x80 -> hit=1, deci=1, target=0x400, ghr unchanged.
- CNT_W=4: 20 consecutive updates with predict_res=1 -> o_bp_mispred_cnt=15; type 000 updates with predict_res=1 leave the count unchanged.
- Same-cycle update (jal pc=0x80, target=0x400) and lookup 0x80 -> without macro: hit=0, target=0x84; with XCORE_BPU_BYPASS_EN: hit=1, target=0x400.
